// File: rtl/uart_lite_rx_poller.sv
// AXI4-Lite poller that drains an AXI UART Lite RX FIFO into a byte stream.
// Ports: clk_i/rst_i (sync, active-high), m_axi_* master, data_o/valid_o/ready_i
// byte stream, rx_count_o and sticky overrun/frame/parity/resp_err/timeout flags.
// Optional: define UART_POLL_FIFO_RST_EN to reset the UART FIFOs via CTRL first.
module uart_lite_rx_poller #(
  parameter int unsigned POLL_GAP  = 8,
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [3:0]  STAT_ADDR = 4'h8,
  parameter logic [3:0]  RX_ADDR   = 4'h0,
  parameter logic [3:0]  CTRL_ADDR = 4'hC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [3:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_bready,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] rx_count_o,
  output logic        overrun_o,
  output logic        frame_o,
  output logic        parity_o,
  output logic        resp_err_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_INIT, S_CFG, S_STAT_AR, S_STAT_R,
    S_WAIT, S_RX_AR, S_RX_R, S_OUT
  } state_e;

  localparam int GW = $clog2(POLL_GAP + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int unsigned GLAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GLAST);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] to_q;
  logic [7:0]    data_q;
  logic [15:0]   cnt_q;
  logic          ovr_q, frm_q, par_q, rerr_q, tout_q;
  logic          aw_done_q, w_done_q;
  logic          in_r, r_err, after_stat;

  assign in_r  = (state_q == S_STAT_R) || (state_q == S_RX_R);
  assign r_err = m_axi_rresp != 2'b00;
  // An idle gap only follows a "no data" or failed status read.
  assign after_stat = (POLL_GAP == 0) ? 1'b0 : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: begin
`ifdef UART_POLL_FIFO_RST_EN
        state_d = S_CFG;
`else
        state_d = S_STAT_AR;
`endif
      end
`ifdef UART_POLL_FIFO_RST_EN
      S_CFG:     if (m_axi_bvalid) state_d = S_STAT_AR;
`else
      S_CFG:     state_d = S_STAT_AR;
`endif
      S_STAT_AR: if (m_axi_arready) state_d = S_STAT_R;
      S_STAT_R: begin
        if (m_axi_rvalid) begin
          if (r_err || !m_axi_rdata[0])
            state_d = after_stat ? S_WAIT : S_STAT_AR;
          else
            state_d = S_RX_AR;
        end
      end
      S_WAIT:    if (gap_q == GAP_LAST) state_d = S_STAT_AR;
      S_RX_AR:   if (m_axi_arready) state_d = S_RX_R;
      S_RX_R: begin
        if (m_axi_rvalid)
          state_d = r_err ? S_STAT_AR : S_OUT;
      end
      S_OUT:     if (ready_i) state_d = S_STAT_AR;
      default:   state_d = S_INIT;
    endcase
  end

  always_comb begin
    m_axi_araddr  = 4'h0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = 4'h0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = 32'h0;
    m_axi_wstrb   = 4'h0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    valid_o       = 1'b0;
    unique case (state_q)
      S_STAT_AR: begin
        m_axi_araddr  = STAT_ADDR;
        m_axi_arvalid = 1'b1;
      end
      S_RX_AR: begin
        m_axi_araddr  = RX_ADDR;
        m_axi_arvalid = 1'b1;
      end
      S_STAT_R, S_RX_R: m_axi_rready = 1'b1;
      S_OUT:            valid_o      = 1'b1;
`ifdef UART_POLL_FIFO_RST_EN
      S_CFG: begin
        m_axi_awaddr  = CTRL_ADDR;
        m_axi_awvalid = !aw_done_q;
        m_axi_wdata   = 32'h3;
        m_axi_wstrb   = 4'hF;
        m_axi_wvalid  = !w_done_q;
        m_axi_bready  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q     <= '0;
      to_q      <= '0;
      data_q    <= 8'h0;
      cnt_q     <= 16'h0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      par_q     <= 1'b0;
      rerr_q    <= 1'b0;
      tout_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      gap_q <= (state_q == S_WAIT) ? gap_q + 1'b1 : '0;
      // Timeout only flags; the read is never abandoned.
      if (in_r && !m_axi_rvalid) begin
        if (to_q != TO_MAX) to_q <= to_q + 1'b1;
        if (to_q + 1'b1 == TO_MAX) tout_q <= 1'b1;
      end else begin
        to_q <= '0;
      end
      if (state_q == S_STAT_R && m_axi_rvalid) begin
        ovr_q <= ovr_q | m_axi_rdata[5];
        frm_q <= frm_q | m_axi_rdata[6];
        par_q <= par_q | m_axi_rdata[7];
      end
      if (in_r && m_axi_rvalid && r_err) rerr_q <= 1'b1;
      if (state_q == S_RX_R && m_axi_rvalid && !r_err)
        data_q <= m_axi_rdata[7:0];
      if (state_q == S_OUT && ready_i) cnt_q <= cnt_q + 16'd1;
`ifdef UART_POLL_FIFO_RST_EN
      if (state_q == S_CFG) begin
        if (m_axi_awready) aw_done_q <= 1'b1;
        if (m_axi_wready)  w_done_q  <= 1'b1;
        if (m_axi_bvalid && m_axi_bresp != 2'b00) rerr_q <= 1'b1;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
`endif
    end
  end

  // Status bits 4:1, upper data and, by default, the write inputs are unused.
  logic unused_in;
  assign unused_in = ^{m_axi_rdata[31:8], m_axi_rdata[4:1],
                       m_axi_awready, m_axi_wready, m_axi_bvalid,
                       m_axi_bresp, aw_done_q, w_done_q, CTRL_ADDR};

  assign data_o     = data_q;
  assign rx_count_o = cnt_q;
  assign overrun_o  = ovr_q;
  assign frame_o    = frm_q;
  assign parity_o   = par_q;
  assign resp_err_o = rerr_q;
  assign timeout_o  = tout_q;

endmodule
